fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage sitting directly upstream of the decode stage. Keeps the architectural PC and issues requests on a req/ack instruction-memory port. Presents one instruction per edge (or an all-zero NOP bubble) on the registers decode samples. Honours decode's redirect (Alt_PC / Request_Alt_PC) with one architectural branch-delay slot, and decode's freeze request (WANT_FREEZE).

Parameters:
RESET_PC, 32'h00400000, PC value loaded at reset.

Ports:
CLK  input  1  clock, all state on rising edge
RESET  input  1  asynchronous, active-low reset
Alt_PC_IN  input  32  redirect target from decode (registered Alt_PC)
Request_Alt_PC_IN  input  1  redirect request from decode
WANT_FREEZE_IN  input  1  decode asks fetch to hold its output and stop advancing
IMem_Addr_OUT  output  32  instruction memory word address (byte address, bits[1:0]=0)
IMem_Req_OUT  output  1  request valid; address held stable until ack
IMem_Ack_IN  input  1  memory returns IMem_Data_IN this cycle; may assert in the same cycle as req
IMem_Data_IN  input  32  instruction word
Instr1_OUT  output  32  instruction to decode; 0 = bubble
Instr_PC_OUT  output  32  PC of Instr1_OUT; 0 for bubble
Instr_PC_Plus4_OUT  output  32  Instr_PC_OUT+4; 0 for bubble
Instr_Valid_OUT  output  1  1 when Instr1_OUT is a real fetched instruction

Behaviour:
- Reset (RESET=0, async):
  - PC=RESET_PC; state=IDLE; all outputs 0; IMem_Req_OUT=0.
  - Skid buffer, squash and redirect_pending cleared.
- States:
  - IDLE: one cycle after reset release. Goes to REQ.
  - REQ: IMem_Req_OUT=1, IMem_Addr_OUT=PC. Stays in REQ while the ack is pending.
  - HOLD: freeze active with the skid buffer full. No request is issued.
- Ack, no freeze, no squash:
  - Next edge: Instr1_OUT=IMem_Data_IN, Instr_PC_OUT=PC, Instr_PC_Plus4_OUT=PC+4, Instr_Valid_OUT=1.
  - PC <= redirect_pending ? pending_target : PC+4; redirect_pending cleared.
  - The next request issues in the following cycle.
  - Throughput: one instruction per cycle when the memory acks in the same cycle.
- No ack and not frozen: the next edge loads a bubble (all four outputs 0).
- Redirect:
  - Sampled only when WANT_FREEZE_IN=0.
  - If Instr_Valid_OUT=1 (delay slot already handed over):
    - PC <= Alt_PC_IN.
    - An ack in the same cycle is discarded and a bubble is delivered.
    - An outstanding request without ack sets squash; its eventual ack is discarded (bubble); then a request to the new PC issues.
    - Skid buffer cleared.
  - If Instr_Valid_OUT=0 (delay slot not yet delivered):
    - redirect_pending=1, pending_target=Alt_PC_IN.
    - The current/next fetch (delay slot) is delivered normally; then PC <= pending_target.
  - A second redirect while redirect_pending=1 overwrites the target.
- Freeze (WANT_FREEZE_IN=1):
  - All outputs hold their values.
  - No new request starts; an outstanding request continues.
  - Its ack is captured into a one-entry skid buffer (data, PC) and PC advances; state becomes HOLD.
  - Squashed acks are not buffered.
- Freeze release:
  - If the buffer is valid, the buffer is delivered at the first unfrozen edge and cleared; the request for the new PC issues in the same cycle.
  - Otherwise normal operation resumes.
- Width: PC+4 wraps modulo 2^32 (32'hFFFFFFFC -> 0). No alignment check; PC[1:0] is always 0.
- Reset mid-request: drop IMem_Req_OUT immediately. The memory's late ack after reset is ignored until state=REQ.

Test Plan:
- Zero-latency memory (ack same cycle), RESET_PC=0x00400000 -> Instr_PC_OUT 0x00400000, 0x00400004, 0x00400008 on consecutive edges; Instr_Valid_OUT=1; Plus4 correct.
- Memory ack after 2 cycles -> two bubble cycles (Instr1_OUT=0, Instr_Valid_OUT=0) between instructions; IMem_Addr_OUT stable while req held.
- Branch at 0x00400010, redirect to 0x00400100 arriving with delay slot 0x00400014 valid; in-flight 0x00400018 acked the same cycle -> 0x00400018 discarded (bubble); next valid PC 0x00400100.
- Same redirect with the delay slot still outstanding (Instr_Valid_OUT=0) -> 0x00400014 delivered, then 0x00400100; 0x00400018 never delivered.
- WANT_FREEZE_IN high 4 cycles while the request for 0x00400020 acks -> outputs hold the prior instruction; on release 0x00400020 is delivered from the buffer, then 0x00400024.
- RESET pulsed low mid-request -> outputs 0 and req 0 immediately; after release, the first fetch is at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, req/ack I-mem port, delay-slot redirect,
// freeze with a one-entry skid buffer feeding the decode registers.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Alt_PC_IN,
  input  logic        Request_Alt_PC_IN,
  input  logic        WANT_FREEZE_IN,
  output logic [31:0] IMem_Addr_OUT,
  output logic        IMem_Req_OUT,
  input  logic        IMem_Ack_IN,
  input  logic [31:0] IMem_Data_IN,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4_OUT,
  output logic        Instr_Valid_OUT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } skid_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  if_id_t      out_q, out_d;
  logic        skid_v_q, skid_v_d;
  skid_t       skid_q, skid_d;
  logic        squash_q, squash_d;
  logic        rpend_q, rpend_d;
  logic [31:0] rtgt_q, rtgt_d;

  logic        ack;
  logic        redir;
  logic        kill;
  logic        defer;
  logic [31:0] seq_pc;

  function automatic if_id_t mk(
    input logic [31:0] i,
    input logic [31:0] p
  );
    if_id_t r;
    r.instr = i;
    r.pc    = p;
    r.pc4   = p + 32'd4;
    r.valid = 1'b1;
    return r;
  endfunction

  // Acks outside REQ (e.g. late ones after reset) are ignored.
  assign ack   = (state_q == S_REQ) && IMem_Ack_IN;
  assign redir = Request_Alt_PC_IN && !WANT_FREEZE_IN;
  assign kill  = redir && out_q.valid;
  assign defer = redir && !out_q.valid;

  always_comb begin
    seq_pc = pc_q + 32'd4;
    if (defer) begin
      seq_pc = Alt_PC_IN;
    end else if (rpend_q) begin
      seq_pc = rtgt_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    out_d    = out_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    squash_d = squash_q;
    rpend_d  = rpend_q;
    rtgt_d   = rtgt_q;
    if (WANT_FREEZE_IN) begin
      if (ack) begin
        if (squash_q) begin
          squash_d = 1'b0;
          pc_d     = rtgt_q;
          state_d  = S_IDLE;
        end else begin
          skid_v_d    = 1'b1;
          skid_d.data = IMem_Data_IN;
          skid_d.pc   = pc_q;
          pc_d        = seq_pc;
          rpend_d     = 1'b0;
          state_d     = S_HOLD;
        end
      end
    end else begin
      out_d   = '0;
      state_d = S_REQ;
      unique case (state_q)
        S_REQ: begin
          if (!IMem_Ack_IN) begin
            // Keep the address stable; retarget once the stale ack lands.
            if (kill || (redir && squash_q)) begin
              squash_d = 1'b1;
              rtgt_d   = Alt_PC_IN;
            end else if (defer) begin
              rpend_d = 1'b1;
              rtgt_d  = Alt_PC_IN;
            end
          end else if (squash_q) begin
            squash_d = 1'b0;
            pc_d     = redir ? Alt_PC_IN : rtgt_q;
          end else if (kill) begin
            pc_d = Alt_PC_IN;
          end else begin
            out_d   = mk(IMem_Data_IN, pc_q);
            pc_d    = seq_pc;
            rpend_d = 1'b0;
          end
        end
        S_HOLD: begin
          skid_v_d = 1'b0;
          if (kill) begin
            pc_d = Alt_PC_IN;
          end else begin
            if (skid_v_q) begin
              out_d = mk(skid_q.data, skid_q.pc);
            end
            if (defer) begin
              pc_d = Alt_PC_IN;
            end
          end
        end
        S_IDLE: begin
          if (kill) begin
            pc_d = Alt_PC_IN;
          end else if (defer) begin
            rpend_d = 1'b1;
            rtgt_d  = Alt_PC_IN;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
      if (kill) begin
        skid_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      out_q    <= '0;
      skid_v_q <= 1'b0;
      skid_q   <= '0;
      squash_q <= 1'b0;
      rpend_q  <= 1'b0;
      rtgt_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      out_q    <= out_d;
      skid_v_q <= skid_v_d;
      skid_q   <= skid_d;
      squash_q <= squash_d;
      rpend_q  <= rpend_d;
      rtgt_q   <= rtgt_d;
    end
  end

  assign IMem_Req_OUT       = (state_q == S_REQ);
  assign IMem_Addr_OUT      = IMem_Req_OUT ? pc_q : '0;
  assign Instr1_OUT         = out_q.instr;
  assign Instr_PC_OUT       = out_q.pc;
  assign Instr_PC_Plus4_OUT = out_q.pc4;
  assign Instr_Valid_OUT    = out_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus a
// hand-written asynchronous reset sequence.
module tb_fetch_stage;

  localparam logic [31:0] B = 32'h0040_0000;

  logic        CLK;
  logic        RESET;
  logic [31:0] alt;
  logic        rq;
  logic        frz;
  logic [31:0] addr;
  logic        req;
  logic        ack;
  logic [31:0] data;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic [31:0] ipc4;
  logic        valid;

  int checks;
  int errors;

  fetch_stage #(.RESET_PC(B)) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .Alt_PC_IN          (alt),
    .Request_Alt_PC_IN  (rq),
    .WANT_FREEZE_IN     (frz),
    .IMem_Addr_OUT      (addr),
    .IMem_Req_OUT       (req),
    .IMem_Ack_IN        (ack),
    .IMem_Data_IN       (data),
    .Instr1_OUT         (instr),
    .Instr_PC_OUT       (ipc),
    .Instr_PC_Plus4_OUT (ipc4),
    .Instr_Valid_OUT    (valid)
  );

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  assign data = f(addr);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        ack;
    logic        frz;
    logic        rq;
    logic [31:0] alt;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ev;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input logic        r,
    input logic        a,
    input logic        fz,
    input logic        q,
    input logic [31:0] t,
    input logic        er,
    input logic [31:0] ea,
    input logic        ev,
    input logic [31:0] ep
  );
    vec_t v;
    v.rst = r; v.ack = a; v.frz = fz; v.rq = q; v.alt = t;
    v.ereq = er; v.eaddr = ea; v.ev = ev; v.epc = ep;
    tbl.push_back(v);
  endtask

  task automatic chk(
    input string       nm,
    input int          row,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  task automatic chk_out(input int row, input logic ev, input logic [31:0] ep);
    chk("valid", row, {31'b0, valid}, {31'b0, ev});
    chk("pc", row, ipc, ev ? ep : 32'h0);
    chk("plus4", row, ipc4, ev ? ep + 32'd4 : 32'h0);
    chk("instr", row, instr, ev ? f(ep) : 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    RESET = 1'b0;
    ack = 1'b0; frz = 1'b0; rq = 1'b0; alt = '0;

    // zero-latency stream
    add(0,0,0,0,0,          0,0,        0,0);
    add(0,1,0,0,0,          1,B,        1,B);
    add(0,1,0,0,0,          1,B+4,      1,B+4);
    add(0,1,0,0,0,          1,B+8,      1,B+8);
    add(0,1,0,0,0,          1,B+'hC,    1,B+'hC);
    // two-cycle latency
    add(0,0,0,0,0,          1,B+'h10,   0,0);
    add(0,0,0,0,0,          1,B+'h10,   0,0);
    add(0,1,0,0,0,          1,B+'h10,   1,B+'h10);
    add(0,0,0,0,0,          1,B+'h14,   0,0);
    add(0,0,0,0,0,          1,B+'h14,   0,0);
    add(0,1,0,0,0,          1,B+'h14,   1,B+'h14);
    // redirect after delay slot handed over; same-cycle ack dropped
    add(0,1,0,1,B+'h100,    1,B+'h18,   0,0);
    add(0,1,0,0,0,          1,B+'h100,  1,B+'h100);
    add(0,1,0,0,0,          1,B+'h104,  1,B+'h104);
    // reset mid-request, late ack in IDLE ignored
    add(1,0,0,0,0,          0,0,        0,0);
    add(0,1,0,0,0,          0,0,        0,0);
    add(0,1,0,0,0,          1,B,        1,B);
    add(0,1,0,0,0,          1,B+4,      1,B+4);
    add(0,1,0,0,0,          1,B+8,      1,B+8);
    add(0,1,0,0,0,          1,B+'hC,    1,B+'hC);
    add(0,1,0,0,0,          1,B+'h10,   1,B+'h10);
    // redirect with delay slot still outstanding
    add(0,0,0,0,0,          1,B+'h14,   0,0);
    add(0,0,0,1,B+'h100,    1,B+'h14,   0,0);
    add(0,1,0,0,0,          1,B+'h14,   1,B+'h14);
    add(0,1,0,0,0,          1,B+'h100,  1,B+'h100);
    // redirect with request in flight: squash its later ack
    add(0,0,0,1,B+'h200,    1,B+'h104,  0,0);
    add(0,1,0,0,0,          1,B+'h104,  0,0);
    add(0,1,0,0,0,          1,B+'h200,  1,B+'h200);
    // freeze while 0x20 acks
    add(1,0,0,0,0,          0,0,        0,0);
    add(0,0,0,0,0,          0,0,        0,0);
    for (int k = 0; k < 8; k++) begin
      add(0,1,0,0,0,        1,B+4*k,    1,B+4*k);
    end
    add(0,1,1,0,0,          1,B+'h20,   1,B+'h1C);
    add(0,0,1,0,0,          0,0,        1,B+'h1C);
    add(0,0,1,0,0,          0,0,        1,B+'h1C);
    add(0,0,1,0,0,          0,0,        1,B+'h1C);
    add(0,0,0,0,0,          0,0,        1,B+'h20);
    add(0,1,0,0,0,          1,B+'h24,   1,B+'h24);
    // PC wrap
    add(0,1,0,1,32'hFFFF_FFFC, 1,B+'h28, 0,0);
    add(0,1,0,0,0,          1,32'hFFFF_FFFC, 1,32'hFFFF_FFFC);
    add(0,1,0,0,0,          1,32'h0,    1,32'h0);

    #1;
    chk("rst_req", -1, {31'b0, req}, 32'h0);
    chk("rst_addr", -1, addr, 32'h0);
    chk_out(-1, 1'b0, 32'h0);
    @(posedge CLK);
    @(posedge CLK);

    foreach (tbl[i]) begin
      @(negedge CLK);
      RESET = !tbl[i].rst;
      ack   = tbl[i].ack;
      frz   = tbl[i].frz;
      rq    = tbl[i].rq;
      alt   = tbl[i].alt;
      #1;
      chk("req", i, {31'b0, req}, {31'b0, tbl[i].ereq});
      chk("addr", i, addr, tbl[i].eaddr);
      @(posedge CLK);
      #1;
      chk_out(i, tbl[i].ev, tbl[i].epc);
    end

    // asynchronous reset between edges drops everything at once
    @(negedge CLK);
    ack = 1'b1; frz = 1'b0; rq = 1'b0;
    @(posedge CLK);
    #1;
    chk_out(100, 1'b1, 32'h4);
    #1;
    RESET = 1'b0;
    #1;
    chk("async_req", 100, {31'b0, req}, 32'h0);
    chk_out(101, 1'b0, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("idle_req", 102, {31'b0, req}, 32'h0);
    @(negedge CLK);
    #1;
    chk("first_req", 103, {31'b0, req}, 32'h1);
    chk("first_addr", 103, addr, B);
    @(posedge CLK);
    #1;
    chk_out(103, 1'b1, B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
